// File: rtl/hbm_pkg.sv
// Shared definitions for the HBM scrub sequencer.
// Contents:
//   CH_W_DEF, ERR_THRESH_DEF  default channel-index width and swap threshold
//   REQ_RD / REQ_WB           encodings carried on req_wr
//   state_t, ST_*             scrub FSM state encoding
package hbm_pkg;

    localparam int CH_W_DEF       = 3;
    localparam int ERR_THRESH_DEF = 4;

    localparam logic REQ_RD = 1'b0;
    localparam logic REQ_WB = 1'b1;

    typedef logic [2:0] state_t;

    localparam state_t ST_IDLE      = 3'd0;
    localparam state_t ST_RD_REQ    = 3'd1;
    localparam state_t ST_RD_WAIT   = 3'd2;
    localparam state_t ST_WB_REQ    = 3'd3;
    localparam state_t ST_WB_WAIT   = 3'd4;
    localparam state_t ST_NEXT      = 3'd5;
    localparam state_t ST_SWAP      = 3'd6;
    localparam state_t ST_SWAP_WAIT = 3'd7;

endpackage

// File: rtl/hbm_scrub_sequencer_if.sv
// Memory request/response bus between the scrub sequencer and the HBM controller.
// Signals:
//   req_valid/req_ready     request handshake (one request outstanding at most)
//   req_wr                  REQ_RD = scrub read, REQ_WB = correcting write-back
//   req_addr, req_ch        word address and channel of the request
//   rsp_valid               response for the outstanding request
//   rsp_corrected           read data had a corrected single-bit error
//   rsp_uncorrectable       read data had a multi-bit error
// Modports: master = sequencer side, slave = controller side.
interface hbm_scrub_sequencer_if #(
    parameter int ADDR_W = 16,
    parameter int CH_W   = 3
);
    logic              req_valid;
    logic              req_ready;
    logic              req_wr;
    logic [ADDR_W-1:0] req_addr;
    logic [CH_W-1:0]   req_ch;
    logic              rsp_valid;
    logic              rsp_corrected;
    logic              rsp_uncorrectable;

    modport master (
        output req_valid, req_wr, req_addr, req_ch,
        input  req_ready, rsp_valid, rsp_corrected, rsp_uncorrectable
    );

    modport slave (
        input  req_valid, req_wr, req_addr, req_ch,
        output req_ready, rsp_valid, rsp_corrected, rsp_uncorrectable
    );
endinterface

// File: rtl/hbm_scrub_addr_gen.sv
// Scrub address counter.
// Ports:
//   clk_2gt, rst_n  clock, synchronous active-low reset
//   clr             restart at address 0
//   inc             advance one word (holds at the last address, never wraps)
//   addr            current scrub address
//   last            current address is all-ones
module hbm_scrub_addr_gen #(
    parameter int ADDR_W = 16
) (
    input  logic              clk_2gt,
    input  logic              rst_n,
    input  logic              clr,
    input  logic              inc,
    output logic [ADDR_W-1:0] addr,
    output logic              last
);
    logic [ADDR_W-1:0] addr_reg;

    always_ff @(posedge clk_2gt) begin
        if (!rst_n) begin
            addr_reg <= '0;
        end else if (clr) begin
            addr_reg <= '0;
        end else if (inc && !last) begin
            addr_reg <= addr_reg + ADDR_W'(1);
        end
    end

    assign addr = addr_reg;
    assign last = &addr_reg;
endmodule

// File: rtl/hbm_scrub_sequencer.sv
// HBM scrub sequencer: on a rising edge of scrub_trigger, walks every word of the
// faulting channel (read, plus write-back for each corrected word), counts corrected
// errors, and requests a hot-spare swap on an uncorrectable error or when the count
// reaches ERR_THRESH.
// Ports:
//   clk_2gt, rst_n        clock, synchronous active-low reset
//   scrub_trigger, err_ch level trigger from the healer and its channel index
//   mem                   request/response bus to the HBM controller (master side)
//   swap_req, swap_ch     hot-spare swap request, held until swap_done
//   swap_done             swap complete pulse
//   busy                  FSM not idle
//   scrub_done            one-cycle pulse when a pass ends without a swap
//   err_count             corrected errors counted in the current pass
module hbm_scrub_sequencer
    import hbm_pkg::*;
#(
    parameter int ADDR_W     = 16,
    parameter int CH_W       = CH_W_DEF,
    parameter int CNT_W      = 8,
    parameter int ERR_THRESH = ERR_THRESH_DEF
) (
    input  logic                 clk_2gt,
    input  logic                 rst_n,
    input  logic                 scrub_trigger,
    input  logic [CH_W-1:0]      err_ch,
    hbm_scrub_sequencer_if.master mem,
    output logic                 swap_req,
    output logic [CH_W-1:0]      swap_ch,
    input  logic                 swap_done,
    output logic                 busy,
    output logic                 scrub_done,
    output logic [CNT_W-1:0]     err_count
);
    localparam logic [CNT_W-1:0] THRESH = CNT_W'(ERR_THRESH);

    state_t            state_reg, state_next;
    logic              trig_q_reg;
    logic              pending_reg;
    logic [CH_W-1:0]   ch_reg;
    logic [CNT_W-1:0]  cnt_reg;

    logic              trig_edge;
    logic              start;
    logic              cnt_inc;
    logic              cnt_clr;
    logic              addr_inc;
    logic              addr_last;
    logic [ADDR_W-1:0] addr;

    assign trig_edge = scrub_trigger && !trig_q_reg;

    hbm_scrub_addr_gen #(.ADDR_W(ADDR_W)) u_addr_gen (
        .clk_2gt (clk_2gt),
        .rst_n   (rst_n),
        .clr     (start),
        .inc     (addr_inc),
        .addr    (addr),
        .last    (addr_last)
    );

    always_comb begin
        state_next = state_reg;
        start      = 1'b0;
        cnt_inc    = 1'b0;
        cnt_clr    = 1'b0;
        addr_inc   = 1'b0;
        case (state_reg)
            ST_IDLE: begin
                // A trigger that arrived while busy starts the next pass here.
                if (trig_edge || pending_reg) begin
                    start      = 1'b1;
                    state_next = ST_RD_REQ;
                end
            end
            ST_RD_REQ: begin
                if (mem.req_ready) state_next = ST_RD_WAIT;
            end
            ST_RD_WAIT: begin
                if (mem.rsp_valid) begin
                    // Uncorrectable outranks corrected when both are flagged.
                    if (mem.rsp_uncorrectable) begin
                        state_next = ST_SWAP;
                    end else if (mem.rsp_corrected) begin
                        cnt_inc    = 1'b1;
                        state_next = ST_WB_REQ;
                    end else begin
                        state_next = ST_NEXT;
                    end
                end
            end
            ST_WB_REQ: begin
                if (mem.req_ready) state_next = ST_WB_WAIT;
            end
            ST_WB_WAIT: begin
                if (mem.rsp_valid) state_next = (cnt_reg >= THRESH) ? ST_SWAP : ST_NEXT;
            end
            ST_NEXT: begin
                if (addr_last) begin
                    state_next = ST_IDLE;
                end else begin
                    addr_inc   = 1'b1;
                    state_next = ST_RD_REQ;
                end
            end
            ST_SWAP: begin
                state_next = ST_SWAP_WAIT;
            end
            ST_SWAP_WAIT: begin
                if (swap_done) begin
                    cnt_clr    = 1'b1;
                    state_next = ST_IDLE;
                end
            end
            default: state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk_2gt) begin
        if (!rst_n) begin
            state_reg   <= ST_IDLE;
            trig_q_reg  <= 1'b0;
            pending_reg <= 1'b0;
            ch_reg      <= '0;
            cnt_reg     <= '0;
        end else begin
            state_reg  <= state_next;
            trig_q_reg <= scrub_trigger;

            // One-deep: further edges while already pending are absorbed.
            if (start) begin
                pending_reg <= 1'b0;
                ch_reg      <= err_ch;
            end else if (trig_edge && state_reg != ST_IDLE) begin
                pending_reg <= 1'b1;
            end

            if (start || cnt_clr) begin
                cnt_reg <= '0;
            end else if (cnt_inc && cnt_reg != '1) begin
                cnt_reg <= cnt_reg + CNT_W'(1);
            end
        end
    end

    assign mem.req_valid = (state_reg == ST_RD_REQ) || (state_reg == ST_WB_REQ);
    assign mem.req_wr    = (state_reg == ST_WB_REQ) ? REQ_WB : REQ_RD;
    assign mem.req_addr  = addr;
    assign mem.req_ch    = ch_reg;

    assign swap_req   = (state_reg == ST_SWAP) || (state_reg == ST_SWAP_WAIT);
    assign swap_ch    = ch_reg;
    assign busy       = (state_reg != ST_IDLE);
    assign scrub_done = (state_reg == ST_NEXT) && addr_last;
    assign err_count  = cnt_reg;
endmodule

// File: tb/tb_hbm_scrub_sequencer.sv
// Scoreboard bench for hbm_scrub_sequencer (ADDR_W=2, ERR_THRESH=2).
// A pass-level reference model pushes the expected request/swap/done events;
// a monitor pops and compares them as the DUT presents them.
module tb_hbm_scrub_sequencer;
    import hbm_pkg::*;

    localparam int ADDR_W = 2;
    localparam int CH_W   = 3;
    localparam int CNT_W  = 8;
    localparam int THRESH = 2;
    localparam int N_ADDR = 1 << ADDR_W;

    logic              clk_2gt = 1'b0;
    logic              rst_n = 1'b0;
    logic              scrub_trigger = 1'b0;
    logic [CH_W-1:0]   err_ch = '0;
    logic              swap_req;
    logic [CH_W-1:0]   swap_ch;
    logic              swap_done = 1'b0;
    logic              busy;
    logic              scrub_done;
    logic [CNT_W-1:0]  err_count;

    hbm_scrub_sequencer_if #(.ADDR_W(ADDR_W), .CH_W(CH_W)) mem_if ();

    hbm_scrub_sequencer #(
        .ADDR_W(ADDR_W), .CH_W(CH_W), .CNT_W(CNT_W), .ERR_THRESH(THRESH)
    ) dut (
        .clk_2gt       (clk_2gt),
        .rst_n         (rst_n),
        .scrub_trigger (scrub_trigger),
        .err_ch        (err_ch),
        .mem           (mem_if),
        .swap_req      (swap_req),
        .swap_ch       (swap_ch),
        .swap_done     (swap_done),
        .busy          (busy),
        .scrub_done    (scrub_done),
        .err_count     (err_count)
    );

    always #5 clk_2gt = ~clk_2gt;

    typedef enum int {K_REQ, K_SWAP, K_DONE} kind_e;
    typedef struct {
        kind_e kind;
        int    wr;
        int    addr;
        int    ch;
        int    cnt;
    } exp_t;

    exp_t exp_q[$];
    int   n_tests = 0;
    int   n_fail  = 0;
    bit   corr_tbl[N_ADDR];
    bit   unc_tbl[N_ADDR];
    int   bp_cnt = 0;
    bit   slow_rsp = 1'b0;
    int   stall_cycles = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, required %0h", name, act, exp);
        end
    endtask

    function automatic exp_t mk(input kind_e k, input int wr, input int addr, input int ch, input int cnt);
        exp_t e;
        e.kind = k; e.wr = wr; e.addr = addr; e.ch = ch; e.cnt = cnt;
        return e;
    endfunction

    // Reference model: what one pass over the channel should produce.
    task automatic model_pass(input int ch, input bit [N_ADDR-1:0] corr, input bit [N_ADDR-1:0] unc,
                              output int cnt_end);
        int cnt = 0;
        bit swapped = 1'b0;
        for (int a = 0; a < N_ADDR && !swapped; a++) begin
            exp_q.push_back(mk(K_REQ, 0, a, ch, 0));
            if (unc[a]) begin
                exp_q.push_back(mk(K_SWAP, 0, 0, ch, cnt));
                swapped = 1'b1;
            end else if (corr[a]) begin
                if (cnt < 255) cnt++;
                exp_q.push_back(mk(K_REQ, 1, a, ch, 0));
                if (cnt >= THRESH) begin
                    exp_q.push_back(mk(K_SWAP, 0, 0, ch, cnt));
                    swapped = 1'b1;
                end
            end
        end
        if (!swapped) exp_q.push_back(mk(K_DONE, 0, 0, 0, cnt));
        cnt_end = swapped ? 0 : cnt;
    endtask

    task automatic check_evt(input kind_e k, input int wr, input int addr, input int ch, input int cnt);
        exp_t e;
        bit ok;
        n_tests++;
        if (exp_q.size() == 0) begin
            n_fail++;
            $display("FAIL evt_unexpected: got %s wr=%0d addr=%0d ch=%0d cnt=%0d, required no event",
                     k.name(), wr, addr, ch, cnt);
            return;
        end
        e = exp_q.pop_front();
        case (k)
            K_REQ:   ok = (e.kind == k) && (wr == e.wr) && (addr == e.addr) && (ch == e.ch);
            K_SWAP:  ok = (e.kind == k) && (ch == e.ch) && (cnt == e.cnt);
            default: ok = (e.kind == k) && (cnt == e.cnt);
        endcase
        if (!ok) begin
            n_fail++;
            $display("FAIL evt_%s: got %s wr=%0d addr=%0d ch=%0d cnt=%0d, required %s wr=%0d addr=%0d ch=%0d cnt=%0d",
                     k.name(), k.name(), wr, addr, ch, cnt, e.kind.name(), e.wr, e.addr, e.ch, e.cnt);
        end else begin
            $display("[TB] %s wr=%0d addr=%0d ch=%0d cnt=%0d", k.name(), wr, addr, ch, cnt);
        end
    endtask

    // Monitor: samples on the falling edge, away from the active edge.
    bit              stall_prev = 1'b0;
    bit              swap_prev  = 1'b0;
    logic [ADDR_W-1:0] s_addr;
    logic            s_wr;
    logic [CH_W-1:0] s_ch;
    initial begin
        forever begin
            @(negedge clk_2gt);
            if (!rst_n) begin
                stall_prev = 1'b0;
                swap_prev  = 1'b0;
                continue;
            end
            if (stall_prev)
                chk("req_hold", {mem_if.req_valid, mem_if.req_wr, mem_if.req_addr, mem_if.req_ch},
                                {1'b1, s_wr, s_addr, s_ch});
            if (mem_if.req_valid && !mem_if.req_ready) begin
                stall_prev = 1'b1;
                stall_cycles++;
                s_wr = mem_if.req_wr; s_addr = mem_if.req_addr; s_ch = mem_if.req_ch;
            end else begin
                stall_prev = 1'b0;
            end
            if (mem_if.req_valid && mem_if.req_ready)
                check_evt(K_REQ, int'(mem_if.req_wr), int'(mem_if.req_addr), int'(mem_if.req_ch), 0);
            if (swap_req && !swap_prev)
                check_evt(K_SWAP, 0, 0, int'(swap_ch), int'(err_count));
            swap_prev = swap_req;
            if (scrub_done)
                check_evt(K_DONE, 0, 0, 0, int'(err_count));
        end
    end

    // Controller model: random ready, random response latency, swap_done after a few cycles,
    // plus noise on rsp_valid/swap_done while the DUT must ignore them.
    bit snap_rst, snap_hs, snap_wr, snap_swap, outstanding, o_wr;
    int snap_addr, o_addr, lat, sw_cnt;
    initial begin
        outstanding = 1'b0; sw_cnt = 0; lat = 0; o_wr = 1'b0; o_addr = 0;
        mem_if.req_ready = 1'b0; mem_if.rsp_valid = 1'b0;
        mem_if.rsp_corrected = 1'b0; mem_if.rsp_uncorrectable = 1'b0;
        forever begin
            @(negedge clk_2gt);
            snap_rst  = rst_n;
            snap_hs   = mem_if.req_valid && mem_if.req_ready;
            snap_wr   = mem_if.req_wr;
            snap_addr = int'(mem_if.req_addr);
            snap_swap = swap_req;
            @(posedge clk_2gt);
            #1;
            mem_if.rsp_valid         = 1'b0;
            mem_if.rsp_corrected     = 1'($urandom_range(0, 1));
            mem_if.rsp_uncorrectable = 1'($urandom_range(0, 1));
            swap_done = 1'b0;
            if (!snap_rst) begin
                outstanding = 1'b0;
                sw_cnt = 0;
                mem_if.req_ready = 1'b0;
            end else begin
                if (snap_hs) begin
                    outstanding = 1'b1;
                    o_wr = snap_wr;
                    o_addr = snap_addr;
                    lat = slow_rsp ? 4 : int'($urandom_range(0, 3));
                end
                if (outstanding) begin
                    if (lat == 0) begin
                        mem_if.rsp_valid = 1'b1;
                        outstanding = 1'b0;
                        if (!o_wr) begin
                            mem_if.rsp_corrected     = corr_tbl[o_addr];
                            mem_if.rsp_uncorrectable = unc_tbl[o_addr];
                        end
                    end else begin
                        lat--;
                    end
                end else begin
                    mem_if.rsp_valid = ($urandom_range(0, 7) == 0);
                end
                if (bp_cnt > 0) begin
                    mem_if.req_ready = 1'b0;
                    bp_cnt--;
                end else begin
                    mem_if.req_ready = ($urandom_range(0, 3) != 0);
                end
                if (snap_swap) begin
                    sw_cnt++;
                    if (sw_cnt == 3) begin
                        swap_done = 1'b1;
                        sw_cnt = 0;
                    end
                end else begin
                    sw_cnt = 0;
                    swap_done = ($urandom_range(0, 7) == 0);
                end
            end
        end
    end

    task automatic check_outputs_zero(input string name);
        chk({name, "_req_valid"},  mem_if.req_valid, 0);
        chk({name, "_req_wr"},     mem_if.req_wr, 0);
        chk({name, "_req_addr"},   mem_if.req_addr, 0);
        chk({name, "_req_ch"},     mem_if.req_ch, 0);
        chk({name, "_swap_req"},   swap_req, 0);
        chk({name, "_swap_ch"},    swap_ch, 0);
        chk({name, "_busy"},       busy, 0);
        chk({name, "_scrub_done"}, scrub_done, 0);
        chk({name, "_err_count"},  err_count, 0);
    endtask

    task automatic wait_idle(input string name);
        int quiet = 0;
        int cyc = 0;
        while (quiet < 3 && cyc < 3000) begin
            @(negedge clk_2gt);
            cyc++;
            if (!busy) quiet++;
            else quiet = 0;
        end
        if (quiet < 3) begin
            n_tests++;
            n_fail++;
            $display("FAIL %s_timeout: busy still 1 after %0d cycles, required 0", name, cyc);
        end
    endtask

    task automatic run_pass(input string name, input int ch, input bit [N_ADDR-1:0] corr,
                            input bit [N_ADDR-1:0] unc, input int bp);
        int exp_cnt;
        for (int a = 0; a < N_ADDR; a++) begin
            corr_tbl[a] = corr[a];
            unc_tbl[a]  = unc[a];
        end
        model_pass(ch, corr, unc, exp_cnt);
        stall_cycles = 0;
        bp_cnt = bp;
        @(posedge clk_2gt);
        #1;
        err_ch = CH_W'(ch);
        scrub_trigger = 1'b1;
        @(negedge clk_2gt);
        chk({name, "_edge_cycle_valid"}, mem_if.req_valid, 0);
        @(negedge clk_2gt);
        chk({name, "_start_valid"}, mem_if.req_valid, 1);
        chk({name, "_start_addr"}, mem_if.req_addr, 0);
        chk({name, "_start_ch"}, mem_if.req_ch, ch);
        // The channel must have been captured at start; later changes are ignored.
        err_ch = CH_W'($urandom_range(0, 7));
        if ($urandom_range(0, 1) == 1) begin
            repeat ($urandom_range(1, 3)) @(posedge clk_2gt);
            #1;
            scrub_trigger = 1'b0;
        end
        wait_idle(name);
        scrub_trigger = 1'b0;
        chk({name, "_queue_empty"}, exp_q.size(), 0);
        chk({name, "_err_count_idle"}, err_count, exp_cnt);
        if (bp > 0) chk({name, "_stall_ge5"}, stall_cycles >= 5, 1);
        exp_q.delete();
    endtask

    initial begin
        int c1, c2;
        bit found;
        int busy_seen;
        bit [N_ADDR-1:0] rc, ru;

        // Reset state
        repeat (3) @(posedge clk_2gt);
        @(negedge clk_2gt);
        check_outputs_zero("reset");
        @(posedge clk_2gt);
        #1;
        rst_n = 1'b1;
        repeat (2) @(posedge clk_2gt);

        run_pass("clean",       5, 4'b0000, 4'b0000, 0);
        run_pass("corrected",   2, 4'b0100, 4'b0000, 0);
        run_pass("thresh_swap", 6, 4'b0011, 4'b0000, 0);
        run_pass("uncorr",      1, 4'b0011, 4'b0010, 0);
        run_pass("backpressure",4, 4'b0000, 4'b0000, 7);

        // Pending trigger: second edge mid-pass starts a pass on channel 3; a third edge is absorbed.
        for (int a = 0; a < N_ADDR; a++) begin corr_tbl[a] = 1'b0; unc_tbl[a] = 1'b0; end
        model_pass(5, 4'b0000, 4'b0000, c1);
        model_pass(3, 4'b0000, 4'b0000, c2);
        @(posedge clk_2gt); #1; err_ch = 3'd5; scrub_trigger = 1'b1;
        repeat (3) @(posedge clk_2gt); #1; scrub_trigger = 1'b0;
        @(posedge clk_2gt); #1; err_ch = 3'd3; scrub_trigger = 1'b1;
        @(posedge clk_2gt); #1; scrub_trigger = 1'b0;
        @(posedge clk_2gt); #1; scrub_trigger = 1'b1;
        wait_idle("pending");
        scrub_trigger = 1'b0;
        chk("pending_queue_empty", exp_q.size(), 0);
        exp_q.delete();

        // Reset during RD_WAIT with a trigger pending: pass abandoned, pending lost.
        model_pass(6, 4'b0000, 4'b0000, c1);
        slow_rsp = 1'b1;
        @(posedge clk_2gt); #1; err_ch = 3'd6; scrub_trigger = 1'b1;
        @(posedge clk_2gt); #1; scrub_trigger = 1'b0;
        @(posedge clk_2gt); #1; scrub_trigger = 1'b1;
        found = 1'b0;
        for (int i = 0; i < 300 && !found; i++) begin
            @(negedge clk_2gt);
            if (mem_if.req_valid && mem_if.req_ready && !mem_if.req_wr && mem_if.req_addr == 1) found = 1'b1;
        end
        chk("rst_reach_rd_wait", found, 1);
        @(posedge clk_2gt); #1;
        rst_n = 1'b0;
        scrub_trigger = 1'b0;
        @(posedge clk_2gt);
        @(negedge clk_2gt);
        check_outputs_zero("midrst");
        exp_q.delete();
        slow_rsp = 1'b0;
        @(posedge clk_2gt); #1;
        rst_n = 1'b1;
        busy_seen = 0;
        repeat (10) begin
            @(negedge clk_2gt);
            if (busy) busy_seen++;
        end
        chk("midrst_no_pending_pass", busy_seen, 0);

        // Randomized passes
        for (int n = 0; n < 20; n++) begin
            for (int a = 0; a < N_ADDR; a++) begin
                rc[a] = ($urandom_range(0, 3) == 0);
                ru[a] = ($urandom_range(0, 7) == 0);
            end
            run_pass("random", int'($urandom_range(0, 7)), rc, ru,
                     ($urandom_range(0, 3) == 0) ? 7 : 0);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail + 1);
        $fatal(1, "watchdog expired");
    end
endmodule
